// File: rtl/encoder83_arbiter.sv
// encoder83_arbiter: captures one-hot request pulses into a pending set and
// offers the highest-priority pending index as a binary code over valid/ready.
// A request stays pending until its code is accepted; repeats collapse and are
// flagged on merged.
module encoder83_arbiter #(
  parameter int unsigned W         = 3,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned N        = 2 ** W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] in,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         out_valid,
  output logic [N-1:0] pending,
  output logic         merged
);

  logic         hs;
  logic         load;
  logic [N-1:0] clr;
  logic [N-1:0] req;
  logic [N-1:0] base;
  logic [N-1:0] pending_nxt;
  logic         merged_nxt;
  logic [W-1:0] enc;

  // Handshake, clear mask, gated requests and priority encode of the survivors
  always_comb begin
    hs          = out_valid & out_ready;
    load        = ~out_valid | hs;
    clr         = '0;
    if (hs) clr[out] = 1'b1;
    req         = en ? in : '0;
    base        = pending & ~clr;
    pending_nxt = base | req;
    merged_nxt  = |(req & base);
    enc         = '0;
    // Scan from lowest to highest priority so the last hit wins
    for (int i = 0; i < int'(N); i++) begin
      int j;
      j = MSB_FIRST ? i : (int'(N) - 1 - i);
      if (base[j]) enc = W'(j);
    end
  end

  // Pending set, merge flag and offered code; new arrivals are only visible next load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      merged    <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      pending <= pending_nxt;
      merged  <= merged_nxt;
      if (load) begin
        out_valid <= |base;
        out       <= enc;
      end
    end
  end

endmodule

// File: tb/tb_encoder83_arbiter.sv
// Self-checking bench for encoder83_arbiter: directed scenarios plus random
// traffic, all compared against a transaction-level reference model.
module tb_encoder83_arbiter;

  localparam int unsigned W         = 3;
  localparam int unsigned N         = 8;
  localparam bit          MSB_FIRST = 1'b1;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [N-1:0] in;
  logic         out_ready;
  logic [W-1:0] out;
  logic         out_valid;
  logic [N-1:0] pending;
  logic         merged;

  encoder83_arbiter #(.W(W), .MSB_FIRST(MSB_FIRST)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in        (in),
    .out_ready (out_ready),
    .out       (out),
    .out_valid (out_valid),
    .pending   (pending),
    .merged    (merged)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: set of outstanding requests and the offered code
  bit [N-1:0] m_pend;
  int         m_out;
  bit         m_valid;
  bit         m_merged;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int top_index(input bit [N-1:0] v);
    if (MSB_FIRST) begin
      for (int i = N - 1; i >= 0; i--) if (v[i]) return i;
    end else begin
      for (int i = 0; i < N; i++) if (v[i]) return i;
    end
    return 0;
  endfunction

  function automatic void model_reset();
    m_pend = '0; m_out = 0; m_valid = 1'b0; m_merged = 1'b0;
  endfunction

  // One clock of the reference: serve, clear, capture
  function automatic void model_clock(input bit e, input bit [N-1:0] r, input bit rdy);
    bit [N-1:0] remaining;
    bit [N-1:0] fresh;
    bit         served;
    served    = m_valid && rdy;
    remaining = m_pend;
    if (served) remaining[m_out] = 1'b0;
    fresh     = e ? r : '0;
    m_merged  = (fresh & remaining) != 0;
    if (!m_valid || served) begin
      m_valid = remaining != 0;
      m_out   = top_index(remaining);
    end
    m_pend = remaining | fresh;
  endfunction

  task automatic compare_all(input string ctx);
    check({ctx, ".out_valid"}, int'(out_valid), int'(m_valid));
    if (m_valid) check({ctx, ".out"}, int'(out), m_out);
    check({ctx, ".pending"}, int'(pending), int'(m_pend));
    check({ctx, ".merged"}, int'(merged), int'(m_merged));
  endtask

  // Advance one clock and compare everything against the model
  task automatic step(input string ctx);
    model_clock(en, in, out_ready);
    @(posedge clk);
    #1;
    compare_all(ctx);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in = '0; out_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("reset.out_valid", int'(out_valid), 0);
    check("reset.pending", int'(pending), 0);
    check("reset.out", int'(out), 0);
    check("reset.merged", int'(merged), 0);
    rst = 1'b0;

    // Single request
    en = 1'b1; in = 8'h10; out_ready = 1'b1;
    step("single1");
    check("single.pend_e1", int'(pending), 'h10);
    in = '0;
    step("single2");
    check("single.out_e2", int'(out), 4);
    check("single.valid_e2", int'(out_valid), 1);
    step("single3");
    check("single.valid_e3", int'(out_valid), 0);
    check("single.pend_e3", int'(pending), 0);

    // Priority drain of all eight
    in = 8'hFF;
    step("drain_cap");
    in = '0;
    for (int i = 0; i < 8; i++) begin
      step("drain");
      check("drain.code", int'(out), 7 - i);
      check("drain.valid", int'(out_valid), 1);
    end
    step("drain_end");
    check("drain.end_valid", int'(out_valid), 0);
    check("drain.end_pend", int'(pending), 0);

    // Back-pressure without preemption
    out_ready = 1'b0; in = 8'h04;
    step("bp_cap");
    in = '0;
    step("bp_offer");
    check("bp.first", int'(out), 2);
    in = 8'h80;
    step("bp_hold1");
    check("bp.hold1", int'(out), 2);
    in = '0;
    step("bp_hold2");
    check("bp.hold2", int'(out), 2);
    step("bp_hold3");
    check("bp.hold3", int'(out), 2);
    out_ready = 1'b1;
    step("bp_next");
    check("bp.second", int'(out), 7);
    check("bp.second_valid", int'(out_valid), 1);
    step("bp_done");
    check("bp.done_valid", int'(out_valid), 0);

    // Enable gating
    en = 1'b0; in = 8'hFF;
    step("gate1");
    check("gate.pend", int'(pending), 0);
    step("gate2");
    check("gate.valid", int'(out_valid), 0);
    en = 1'b1; in = 8'h01;
    step("gate_cap");
    in = '0;
    step("gate_offer");
    check("gate.out", int'(out), 0);
    check("gate.valid_on", int'(out_valid), 1);
    step("gate_done");

    // Merge, then re-request on the handshake edge
    out_ready = 1'b0; in = 8'h08;
    step("merge_cap");
    in = '0;
    step("merge_offer");
    check("merge.offer", int'(out), 3);
    in = 8'h08;
    step("merge_hit");
    check("merge.pulse", int'(merged), 1);
    check("merge.pend", int'(pending), 'h08);
    in = '0;
    step("merge_clear");
    check("merge.pulse_end", int'(merged), 0);
    out_ready = 1'b1; in = 8'h08;
    step("rereq_hs");
    check("rereq.merged", int'(merged), 0);
    check("rereq.pend", int'(pending), 'h08);
    in = '0;
    step("rereq_offer");
    check("rereq.code", int'(out), 3);
    check("rereq.valid", int'(out_valid), 1);
    step("rereq_done");

    // Asynchronous reset mid-transaction
    out_ready = 1'b0; in = 8'hA5;
    step("rst_cap");
    in = '0;
    step("rst_offer");
    check("rst.pre_pend", int'(pending), 'hA5);
    check("rst.pre_valid", int'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst.async_valid", int'(out_valid), 0);
    check("rst.async_pend", int'(pending), 0);
    check("rst.async_out", int'(out), 0);
    check("rst.async_merged", int'(merged), 0);
    en = 1'b1; in = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst.held_valid", int'(out_valid), 0);
      check("rst.held_pend", int'(pending), 0);
    end
    rst = 1'b0; in = '0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      in        = N'($urandom & $urandom & $urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      step("rand");
    end
    en = 1'b0; in = '0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step("flush");
    check("flush.pend", int'(pending), 0);
    check("flush.valid", int'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/encoder83_arbiter.md
Name: encoder83_arbiter

Overview:
- Registered 8:3 priority encoder with request capture; it works in the opposite direction to the team's 3:8 decoder.
- One-bit request pulses on an 8-bit vector are latched into a pending register.
- The block emits the 3-bit index of the highest-priority pending request with a valid/ready handshake.
- The served request is cleared only when the consumer accepts it.
- Intended for collecting one-hot events from decoder-driven logic and returning them as binary codes, one per transaction.

Parameters:
- W, 3, code width; request vector width N = 2**W (8 by default).
- MSB_FIRST, 1, 1: bit N-1 has highest priority; 0: bit 0 has highest priority.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  request enable; `in` is ignored when en=0.
- in  input  N  request pulses; each set bit is one new request, sampled at the rising edge while en=1.
- out_ready  input  1  consumer accepts `out` this cycle.
- out  output  W  encoded index of the request being offered.
- out_valid  output  1  `out` holds a valid code.
- pending  output  N  registered set of outstanding requests, including the one being offered.
- merged  output  1  one-cycle pulse: a request arrived on a bit that was already pending and was not cleared that edge.

Behaviour:
- Reset (async, rst=1): pending=0, out=0, out_valid=0, merged=0. Reset takes effect immediately, mid-transaction included. Any offered code and all pending requests are discarded.
- Definitions (all registered at the rising edge):
  - hs = out_valid & out_ready.
  - clr = hs ? onehot(out) : 0.
  - new = en ? in : 0.
- pending update: pending <= (pending & ~clr) | new. On simultaneous clear and new of the same bit, the set wins; it counts as a fresh request and is served again.
- merged update: merged <= |(new & pending & ~clr).
- Output load condition: load = ~out_valid | hs.
  - If load: base = pending & ~clr, using the registered value only; same-edge arrivals are not visible.
  - If load: out_valid <= |base.
  - If load: out <= index of the highest-priority set bit of base; out <= 0 when base=0.
  - If not load: out and out_valid hold.
- No preemption: while out_valid=1 and out_ready=0, `out` stays stable even if a higher-priority request arrives.
- Latency:
  - A request sampled at edge k appears in pending after edge k.
  - If idle, out_valid=1 after edge k+1, i.e. two clocks from request to code.
  - Back-to-back service with out_ready held at 1 gives one code per cycle.
- out_ready while out_valid=0 has no effect.
- en=0 blocks capture only; already-pending requests continue to be served.
- All-ones input: eight codes are served in priority order, 7,6,...,0 when MSB_FIRST=1.
- pending never overflows; repeat requests collapse into one and are flagged on `merged`.

Test Plan:
- Reset check: assert rst mid-operation with pending=8'hA5 and out_valid=1. Required: out_valid, pending, out and merged go to 0 without waiting for a clock edge, and stay there until rst deasserts.
- Single request: en=1, in=8'h10 for one cycle, out_ready=1. Required: pending=8'h10 after edge 1; out=4, out_valid=1 after edge 2; pending=0, out_valid=0 after edge 3.
- Priority drain: en=1, in=8'hFF for one cycle, out_ready=1. Required: out sequence 7,6,5,4,3,2,1,0 on consecutive cycles, then out_valid=0 and pending=0.
- Back-pressure, no preemption: in=8'h04, out_ready=0 until out=2 is offered. Then pulse in=8'h80 and hold out_ready=0 for 3 cycles. Required: out stays 2 throughout. Then raise out_ready=1; required codes are 2, then 7.
- Enable gating: en=0 with in=8'hFF. Required: pending stays 0 and out_valid stays 0. Then en=1 with in=8'h01; required: out=0 with out_valid=1 two cycles later.
- Merge and re-request:
  - Hold out=3 with out_ready=0 and pulse in=8'h08. Required: merged=1 for one cycle, pending stays 8'h08.
  - Then, on the handshake edge, pulse in=8'h08 again. Required: merged=0, pending stays 8'h08, and code 3 is offered a second time.
